// File: rtl/reg_ram_initiator.sv
// Burst initiator for the 8-byte register RAM: one request of 1-8 beats becomes a series of RAM accesses.
// Optional macro READBACK_VERIFY_EN adds a one-cycle read-back compare after every written beat.
module reg_ram_initiator #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [AW-1:0] req_len,
    input  logic          wdata_valid,
    output logic          wdata_ready,
    input  logic [DW-1:0] wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          busy_out,
    output logic          done_out,
    output logic          err_out,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    output logic          ram_en,
    input  logic [DW-1:0] ram_rdata
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, RESP, VERIFY} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] beats_q, beats_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          done_q, done_d;
    logic          en, we, step;
`ifdef READBACK_VERIFY_EN
    logic          err_q, err_d;
    logic [DW-1:0] wbeat_q, wbeat_d;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        beats_d     = beats_q;
        rsp_data_d  = rsp_data_q;
        done_d      = 1'b0;
        step        = 1'b0;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        rsp_valid   = 1'b0;
        en          = 1'b0;
        we          = 1'b0;
        ram_wdata   = '0;
`ifdef READBACK_VERIFY_EN
        err_d       = err_q;
        wbeat_d     = wbeat_q;
`endif
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    beats_d = req_len;
                    state_d = req_write ? WRITE : READ;
`ifdef READBACK_VERIFY_EN
                    err_d   = 1'b0;
`endif
                end
            end
            WRITE: begin
                wdata_ready = 1'b1;
                en          = 1'b1;
                we          = wdata_valid;
                ram_wdata   = wdata;
                if (wdata_valid) begin
`ifdef READBACK_VERIFY_EN
                    wbeat_d = wdata;
                    state_d = VERIFY;
`else
                    step    = 1'b1;
`endif
                end
            end
            VERIFY: begin
`ifdef READBACK_VERIFY_EN
                // Same address, write disabled: ram_rdata now shows what the RAM kept
                en      = 1'b1;
                if (ram_rdata != wbeat_q) err_d = 1'b1;
                state_d = WRITE;
                step    = 1'b1;
`else
                state_d = IDLE;
`endif
            end
            READ: begin
                en         = 1'b1;
                rsp_data_d = ram_rdata;
                state_d    = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = READ;
                    step    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Beat completion: advance with wrap, and finish the burst on the last beat
        if (step) begin
            addr_d  = addr_q + AW'(1);
            beats_d = beats_q - AW'(1);
            if (beats_q == '0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            beats_q    <= '0;
            rsp_data_q <= '0;
            done_q     <= 1'b0;
`ifdef READBACK_VERIFY_EN
            err_q      <= 1'b0;
            wbeat_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            beats_q    <= beats_d;
            rsp_data_q <= rsp_data_d;
            done_q     <= done_d;
`ifdef READBACK_VERIFY_EN
            err_q      <= err_d;
            wbeat_q    <= wbeat_d;
`endif
        end
    end

    // Gating with rst_in keeps the RAM untouched on every reset cycle
    assign ram_en      = en & ~rst_in;
    assign ram_we      = we & ~rst_in;
    assign ram_address = addr_q;
    assign rsp_data    = rsp_data_q;
    assign busy_out    = (state_q != IDLE);
    assign done_out    = done_q;
`ifdef READBACK_VERIFY_EN
    assign err_out     = err_q;
`else
    assign err_out     = 1'b0;
`endif
endmodule

// File: tb/tb_reg_ram_initiator.sv
// Self-checking bench for reg_ram_initiator: behavioural RAM plus an array model of its expected contents.
module tb_reg_ram_initiator;
    logic       clk = 1'b0;
    logic       rst_in = 1'b1;
    logic       req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [2:0] req_addr = '0, req_len = '0;
    logic       wdata_valid = 1'b0, wdata_ready;
    logic [7:0] wdata = '0;
    logic       rsp_valid, rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       busy_out, done_out, err_out;
    logic [2:0] ram_address;
    logic [7:0] ram_wdata, ram_rdata;
    logic       ram_we, ram_en;

    logic [7:0] ram [8]     = '{default: 8'h00};
    logic [7:0] exp_mem [8] = '{default: 8'h00};
    logic [7:0] wbuf [8];
    logic       corrupt = 1'b0;
    int         wr_cnt = 0, done_cnt = 0;
    int         errs = 0, checks = 0;

    always #5 clk = ~clk;

    reg_ram_initiator dut (
        .clk_in(clk), .rst_in(rst_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy_out(busy_out), .done_out(done_out), .err_out(err_out),
        .ram_address(ram_address), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_en(ram_en), .ram_rdata(ram_rdata)
    );

    // RAM model: synchronous write, combinational read; bit0 of addr 2 can be corrupted on read
    assign ram_rdata = ram[ram_address] ^ ((corrupt && ram_address == 3'd2) ? 8'h01 : 8'h00);
    always @(posedge clk) begin
        if (ram_en && ram_we) begin
            ram[ram_address] <= ram_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end
    always @(negedge clk) if (done_out) done_cnt <= done_cnt + 1;

    task automatic do_write(input logic [2:0] a, input logic [2:0] len, input int gap);
        int wc0, dc0, n, cyc;
        logic [2:0] ix;
        wc0 = wr_cnt; dc0 = done_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_len = len;
        #1;
        checks++; if (req_ready !== 1'b1) begin errs++; $display("FAIL wr_req_ready: got %b want 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0; req_addr = 3'($urandom); req_len = 3'($urandom);
        #1;
        checks++; if (busy_out !== 1'b1 || req_ready !== 1'b0) begin
            errs++; $display("FAIL wr_busy: got busy=%b ready=%b want 1/0", busy_out, req_ready); end
        n = 0; cyc = 0;
        while (n <= int'(len) && cyc < 200) begin
            wdata_valid = (int'($urandom_range(99)) >= gap);
            wdata = wbuf[n];
            #1;
            if (wdata_valid && wdata_ready) n++;
            @(negedge clk); cyc++;
        end
        wdata_valid = 1'b0;
        checks++; if (n != int'(len) + 1) begin errs++; $display("FAIL wr_beats: got %0d want %0d", n, int'(len) + 1); end
        #1; cyc = 0;
        while (!done_out && cyc < 4) begin @(negedge clk); #1; cyc++; end
        checks++; if (done_out !== 1'b1 || req_ready !== 1'b1) begin
            errs++; $display("FAIL wr_done: got done=%b ready=%b want 1/1", done_out, req_ready); end
        for (int i = 0; i <= int'(len); i++) begin ix = a + 3'(i); exp_mem[ix] = wbuf[i]; end
        @(negedge clk); #1;
        checks++; if (done_out !== 1'b0 || done_cnt - dc0 != 1) begin
            errs++; $display("FAIL wr_done_pulse: got done=%b pulses=%0d want 0/1", done_out, done_cnt - dc0); end
        checks++; if (wr_cnt - wc0 != int'(len) + 1) begin
            errs++; $display("FAIL wr_ram_writes: got %0d want %0d", wr_cnt - wc0, int'(len) + 1); end
    endtask

    // rdy: percentage of cycles with rsp_ready=1; 101 means strict 1/0 toggling
    task automatic do_read(input logic [2:0] a, input logic [2:0] len, input int rdy);
        int dc0, n, cyc;
        logic stall;
        logic [7:0] held;
        logic [2:0] ix;
        dc0 = done_cnt; stall = 1'b0; held = '0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = len;
        #1;
        checks++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rd_req_ready: got %b want 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0; req_addr = 3'($urandom); req_len = 3'($urandom);
        n = 0; cyc = 0;
        while (n <= int'(len) && cyc < 300) begin
            rsp_ready = (rdy > 100) ? cyc[0] : (int'($urandom_range(99)) < rdy);
            #1;
            if (rsp_valid) begin
                if (stall) begin
                    checks++; if (rsp_data !== held) begin
                        errs++; $display("FAIL rd_stable: got %h want %h", rsp_data, held); end
                end
                if (rsp_ready) begin
                    ix = a + 3'(n);
                    checks++; if (rsp_data !== exp_mem[ix]) begin
                        errs++; $display("FAIL rd_data[%0d] addr %0d: got %h want %h", n, ix, rsp_data, exp_mem[ix]); end
                    n++; stall = 1'b0;
                end else begin
                    stall = 1'b1; held = rsp_data;
                end
            end
            @(negedge clk); cyc++;
        end
        rsp_ready = 1'b0;
        #1;
        checks++; if (n != int'(len) + 1) begin errs++; $display("FAIL rd_beats: got %0d want %0d", n, int'(len) + 1); end
        checks++; if (done_out !== 1'b1 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errs++; $display("FAIL rd_done: got done=%b ready=%b valid=%b want 1/1/0", done_out, req_ready, rsp_valid); end
        @(negedge clk); #1;
        checks++; if (done_cnt - dc0 != 1) begin errs++; $display("FAIL rd_done_pulse: got %0d want 1", done_cnt - dc0); end
    endtask

    task automatic test_reset();
        rst_in = 1'b1; req_valid = 1'b1; req_write = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            checks++; if (ram_en !== 1'b0 || busy_out !== 1'b0 || rsp_valid !== 1'b0 || done_out !== 1'b0 ||
                          err_out !== 1'b0 || wdata_ready !== 1'b0 || rsp_data !== 8'h00) begin
                errs++; $display("FAIL reset_state: en=%b busy=%b rv=%b done=%b err=%b wr=%b rd=%h want all 0",
                                 ram_en, busy_out, rsp_valid, done_out, err_out, wdata_ready, rsp_data); end
        end
        rst_in = 1'b0; req_valid = 1'b0;
        @(negedge clk); #1;
        checks++; if (req_ready !== 1'b1 || busy_out !== 1'b0 || wr_cnt != 0) begin
            errs++; $display("FAIL reset_release: ready=%b busy=%b writes=%0d want 1/0/0", req_ready, busy_out, wr_cnt); end
    endtask

    task automatic test_single();
        wbuf[0] = 8'hA5;
        do_write(3'd3, 3'd0, 0);
        do_read(3'd3, 3'd0, 100);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 8; i++) wbuf[i] = 8'h00;
        do_write(3'd0, 3'd7, 0);
        for (int i = 0; i < 4; i++) wbuf[i] = 8'h10 + 8'(i);
        do_write(3'd6, 3'd3, 0);
        do_read(3'd0, 3'd7, 100);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
        do_write(3'd5, 3'd4, 60);
        do_read(3'd5, 3'd2, 101);
    endtask

    task automatic test_reset_mid();
        int dc0, wc0, cyc;
        dc0 = done_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd4; req_len = 3'd3; rsp_ready = 1'b1;
        @(negedge clk); req_valid = 1'b0;
        #1; cyc = 0;
        while (!rsp_valid && cyc < 5) begin @(negedge clk); #1; cyc++; end
        @(negedge clk); rsp_ready = 1'b0;
        #1; cyc = 0;
        while (!rsp_valid && cyc < 5) begin @(negedge clk); #1; cyc++; end
        checks++; if (rsp_valid !== 1'b1) begin errs++; $display("FAIL mid_second_beat: got %b want 1", rsp_valid); end
        rst_in = 1'b1;
        @(negedge clk); rst_in = 1'b0;
        #1;
        checks++; if (busy_out !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 || done_out !== 1'b0) begin
            errs++; $display("FAIL mid_reset_idle: busy=%b rv=%b ready=%b done=%b want 0/0/1/0",
                             busy_out, rsp_valid, req_ready, done_out); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (done_cnt != dc0) begin errs++; $display("FAIL mid_no_done: got %0d pulses want 0", done_cnt - dc0); end
        // Reset while a write beat is offered: the RAM must not see it
        wc0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd1; req_len = 3'd2;
        @(negedge clk);
        req_valid = 1'b0; wdata_valid = 1'b1; wdata = 8'h77; rst_in = 1'b1;
        #1;
        checks++; if (ram_en !== 1'b0 || ram_we !== 1'b0) begin
            errs++; $display("FAIL mid_reset_gate: en=%b we=%b want 0/0", ram_en, ram_we); end
        @(negedge clk); rst_in = 1'b0; wdata_valid = 1'b0;
        #1;
        checks++; if (wr_cnt != wc0 || busy_out !== 1'b0) begin
            errs++; $display("FAIL mid_reset_write: writes=%0d busy=%b want 0/0", wr_cnt - wc0, busy_out); end
        for (int i = 0; i < 4; i++) wbuf[i] = 8'hC0 + 8'(i);
        do_write(3'd4, 3'd3, 0);
        do_read(3'd4, 3'd3, 100);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) wbuf[i] = 8'($urandom);
        do_write(3'd7, 3'd2, 0);
        do_read(3'd7, 3'd2, 100);
        do_read(3'd0, 3'd0, 100);
    endtask

    task automatic test_random();
        logic [2:0] a, l;
        for (int k = 0; k < 16; k++) begin
            a = 3'($urandom); l = 3'($urandom);
            if ($urandom_range(1) == 1) begin
                for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
                do_write(a, l, int'($urandom_range(50)));
            end else begin
                do_read(a, l, 30 + int'($urandom_range(70)));
            end
        end
        checks++; if (err_out !== 1'b0) begin errs++; $display("FAIL rand_err: got %b want 0", err_out); end
    endtask

    task automatic test_verify();
        corrupt = 1'b1;
        wbuf[0] = 8'hFF;
        do_write(3'd2, 3'd0, 0);
`ifdef READBACK_VERIFY_EN
        checks++; if (err_out !== 1'b1) begin errs++; $display("FAIL verify_err: got %b want 1", err_out); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (err_out !== 1'b1) begin errs++; $display("FAIL verify_sticky: got %b want 1", err_out); end
        corrupt = 1'b0;
        do_read(3'd2, 3'd0, 100);
        checks++; if (err_out !== 1'b0) begin errs++; $display("FAIL verify_clear: got %b want 0", err_out); end
`else
        checks++; if (err_out !== 1'b0) begin errs++; $display("FAIL verify_tied: got %b want 0", err_out); end
        corrupt = 1'b0;
        do_read(3'd2, 3'd0, 100);
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_verify();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
